// File: rtl/neuron_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : neuron_link_pkg
// Description : Shared definitions for the bit-serial NEURON link (word
//               width, bit counter width, serialiser state encoding).
//               Also used by the output collector.
// Revision    : 1.0 - initial release
// ============================================================================
package neuron_link_pkg;

    localparam int WORD_W    = 8;
    localparam int BIT_CNT_W = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } feeder_state_t;

endpackage : neuron_link_pkg
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// Module      : byte_fifo
// Description : Small synchronous FIFO of WORD_W-bit entries.
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push       : write push_data; ignored while full (no write-through)
//   pop        : drop the head entry; ignored while empty
//   head       : current head entry (valid when count != 0)
//   count      : occupancy, 0..DEPTH
//   full       : count == DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module byte_fifo
    import neuron_link_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic [WORD_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && (count_q != '0);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule : byte_fifo
`default_nettype wire

// File: rtl/neuron_feeder.sv
`default_nettype none
// ============================================================================
// Module      : neuron_feeder
// Description : Buffers signed 8-bit activations and serialises them LSB
//               first onto a REQ/ACK/DATA bit-serial link.
//   CLK, RST           : clock, synchronous active-high reset
//   IN_VALID/IN_READY  : parallel producer handshake, IN_DATA = activation
//   OUT_REQ            : sink ready for a word
//   OUT_ACK            : one-cycle pulse that accompanies bit 0
//   OUT_DATA           : serial data bit
//   COUNT              : FIFO occupancy (excludes the word being shifted)
//   BUSY               : high for the 8 cycles a word is on the link
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_feeder
    import neuron_link_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [WORD_W-1:0] IN_DATA,
    input  logic              OUT_REQ,
    output logic              OUT_ACK,
    output logic              OUT_DATA,
    output logic [CNT_W-1:0]  COUNT,
    output logic              BUSY
);

    feeder_state_t        state_q, state_d;
    logic [WORD_W-1:0]    shift_q, shift_d;
    logic [BIT_CNT_W-1:0] bitcnt_q, bitcnt_d;
    logic                 armed_q, armed_d;
    logic                 ack_q, ack_d;
    logic                 data_q, data_d;
    logic                 busy_q, busy_d;

    logic [WORD_W-1:0]    fifo_head;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_full;
    logic                 start;

    byte_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RST),
        .push      (IN_VALID),
        .push_data (IN_DATA),
        .pop       (start),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full)
    );

    assign IN_READY = !fifo_full;
    assign COUNT    = fifo_count;
    assign OUT_ACK  = ack_q;
    assign OUT_DATA = data_q;
    assign BUSY     = busy_q;

    // The sink keeps REQ high until one cycle after it sees ACK, so a word
    // may only start once REQ has been observed low since the last start.
    assign start = (state_q == IDLE) && OUT_REQ && armed_q && (fifo_count != '0);

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        armed_d  = armed_q;
        ack_d    = 1'b0;
        data_d   = 1'b0;
        busy_d   = busy_q;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    shift_d  = fifo_head;
                    ack_d    = 1'b1;
                    data_d   = fifo_head[0];
                    bitcnt_d = BIT_CNT_W'(1);
                    busy_d   = 1'b1;
                    armed_d  = 1'b0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                // bitcnt wraps to 0 after bit 7 went out: that edge closes
                // the word and returns to IDLE with the link quiet.
                if (bitcnt_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    data_d   = shift_q[bitcnt_q];
                    bitcnt_d = bitcnt_q + BIT_CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
        if (!OUT_REQ) begin
            armed_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            bitcnt_q <= '0;
            armed_q  <= 1'b1;
            ack_q    <= 1'b0;
            data_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            armed_q  <= armed_d;
            ack_q    <= ack_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
        end
    end

endmodule : neuron_feeder
`default_nettype wire

// File: tb/tb_neuron_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_feeder
// Description : Self-checking bench for neuron_feeder. A word-level model
//               (queue plus link phase) predicts every output each cycle,
//               and a serial sink reassembles words and compares them to
//               the accepted push order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_feeder;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             CLK;
    logic             RST;
    logic             IN_VALID;
    logic             IN_READY;
    logic [7:0]       IN_DATA;
    logic             OUT_REQ;
    logic             OUT_ACK;
    logic             OUT_DATA;
    logic [CNT_W-1:0] COUNT;
    logic             BUSY;

    neuron_feeder #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .IN_DATA  (IN_DATA),
        .OUT_REQ  (OUT_REQ),
        .OUT_ACK  (OUT_ACK),
        .OUT_DATA (OUT_DATA),
        .COUNT    (COUNT),
        .BUSY     (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [7:0] m_q[$];       // words waiting in the feeder
    logic [7:0] sent_q[$];    // accepted words not yet seen on the link
    logic [7:0] m_cur;
    int         m_phase;      // -1 idle, else index of the bit on the link
    logic       m_armed;
    logic       exp_ack, exp_data, exp_busy;

    // Serial sink
    logic       rx_active;
    int         rx_idx;
    logic [7:0] rx_word;
    logic [7:0] last_word;
    int         rx_words;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d, input logic req, input logic r);
        bit push_ok;
        if (r) begin
            m_q.delete();
            sent_q.delete();
            m_phase  = -1;
            m_armed  = 1'b1;
            exp_ack  = 1'b0;
            exp_data = 1'b0;
            exp_busy = 1'b0;
            return;
        end
        push_ok  = v && (m_q.size() != DEPTH);
        exp_ack  = 1'b0;
        exp_data = 1'b0;
        if (m_phase < 0) begin
            exp_busy = 1'b0;
            if (req && m_armed && m_q.size() != 0) begin
                m_cur    = m_q.pop_front();
                m_phase  = 0;
                m_armed  = 1'b0;
                exp_ack  = 1'b1;
                exp_data = m_cur[0];
                exp_busy = 1'b1;
            end
        end else if (m_phase < 7) begin
            m_phase++;
            exp_data = m_cur[m_phase];
            exp_busy = 1'b1;
        end else begin
            m_phase  = -1;
            exp_busy = 1'b0;
        end
        if (!req) m_armed = 1'b1;
        if (push_ok) begin
            m_q.push_back(d);
            sent_q.push_back(d);
        end
    endtask

    task automatic sink(input logic r);
        if (r) begin
            rx_active = 1'b0;
        end else if (OUT_ACK) begin
            rx_active  = 1'b1;
            rx_idx     = 1;
            rx_word    = '0;
            rx_word[0] = OUT_DATA;
        end else if (rx_active) begin
            rx_word[rx_idx] = OUT_DATA;
            rx_idx++;
            if (rx_idx == 8) begin
                rx_active = 1'b0;
                rx_words++;
                last_word = rx_word;
                if (sent_q.size() == 0)
                    check("rx_word_unexpected", {24'd0, rx_word}, 32'hFFFF_FFFF);
                else
                    check("rx_word", {24'd0, rx_word}, {24'd0, sent_q.pop_front()});
            end
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic req, input logic r);
        IN_VALID = v;
        IN_DATA  = d;
        OUT_REQ  = req;
        RST      = r;
        @(posedge CLK);
        model_edge(v, d, req, r);
        #1;
        check("ack",   {31'd0, OUT_ACK},  {31'd0, exp_ack});
        check("data",  {31'd0, OUT_DATA}, {31'd0, exp_data});
        check("busy",  {31'd0, BUSY},     {31'd0, exp_busy});
        check("count", 32'(COUNT),        32'(m_q.size()));
        check("ready", {31'd0, IN_READY}, {31'd0, (m_q.size() != DEPTH)});
        sink(r);
        @(negedge CLK);
    endtask

    task automatic idle(input int n, input logic req);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, req, 1'b0);
    endtask

    initial begin
        int w0;
        IN_VALID  = 1'b0;
        IN_DATA   = '0;
        OUT_REQ   = 1'b1;
        RST       = 1'b1;
        m_phase   = -1;
        m_armed   = 1'b1;
        exp_ack   = 1'b0;
        exp_data  = 1'b0;
        exp_busy  = 1'b0;
        rx_active = 1'b0;
        rx_idx    = 0;
        rx_word   = '0;
        last_word = '0;
        rx_words  = 0;
        @(negedge CLK);

        // 1: single word 5A
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        check("t1_count_after_push", 32'(COUNT), 32'd1);
        idle(10, 1'b1);
        check("t1_word", {24'd0, last_word}, 32'h5A);

        // 2: REQ held high -> only one word leaves
        idle(1, 1'b0);
        step(1'b1, 8'h81, 1'b1, 1'b0);
        step(1'b1, 8'h7F, 1'b1, 1'b0);
        w0 = rx_words;
        idle(12, 1'b1);
        check("t2_one_word", 32'(rx_words - w0), 32'd1);
        check("t2_word_81", {24'd0, last_word}, 32'h81);
        check("t2_count_1", 32'(COUNT), 32'd1);
        idle(1, 1'b0);
        idle(10, 1'b1);
        check("t2_word_7f", {24'd0, last_word}, 32'h7F);

        // 3: overfill with REQ low, then drain
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
        check("t3_full_ready", {31'd0, IN_READY}, 32'd0);
        check("t3_full_count", 32'(COUNT), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            idle(1, 1'b0);
            idle(10, 1'b1);
        end
        check("t3_drained", 32'(COUNT), 32'd0);
        idle(1, 1'b0);
        step(1'b1, 8'hC3, 1'b1, 1'b0);
        idle(10, 1'b1);
        check("t3_word_c3", {24'd0, last_word}, 32'hC3);

        // 4: reset on the 4th bit of FF
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b1, 8'hFF, 1'b1, 1'b0);
        idle(4, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        check("t4_ack_low", {31'd0, OUT_ACK}, 32'd0);
        check("t4_data_low", {31'd0, OUT_DATA}, 32'd0);
        step(1'b1, 8'h01, 1'b1, 1'b0);
        idle(10, 1'b1);
        check("t4_word_01", {24'd0, last_word}, 32'h01);

        // 6: push on the pop edge with COUNT=1
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b1, 1'b0);
        check("t6_count_held", 32'(COUNT), 32'd1);
        idle(10, 1'b1);
        check("t6_word_11", {24'd0, last_word}, 32'h11);
        idle(1, 1'b0);
        idle(10, 1'b1);
        check("t6_word_22", {24'd0, last_word}, 32'h22);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0));
        end
        idle(2, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            idle(1, 1'b0);
            idle(10, 1'b1);
        end
        check("final_empty", 32'(COUNT), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_neuron_feeder
`default_nettype wire
